// File: rtl/input_gpio_loader.sv
// input_gpio_loader: GPIO strobe/ack byte receiver writing an image into data memory at consecutive addresses.
module input_gpio_loader #(
    parameter int                ADDR_W      = 18,
    parameter logic [ADDR_W-1:0] IMAGE_BYTES = 18'd76800,
    parameter logic [ADDR_W-1:0] BASE_SEL0   = 18'h00000,
    parameter logic [ADDR_W-1:0] BASE_SEL1   = 18'h1E846
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              selected,
    input  logic [7:0]        in_data,
    input  logic              in_strobe,
    output logic              in_ack,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        wdata,
    output logic              wren,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, WAIT_REQ, WRITE, ACK_HI, DONE} state_t;
    state_t            state, state_n;
    logic              sync_a, strobe_s;
    logic [ADDR_W-1:0] base, count, count_inc;
    logic [7:0]        data_q;
    assign count_inc = count + ADDR_W'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a   <= 1'b0;
            strobe_s <= 1'b0;
        end else begin
            sync_a   <= in_strobe;
            strobe_s <= sync_a;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // in_data is captured unsynchronized; the host keeps it stable until it sees in_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base   <= '0;
            count  <= '0;
            data_q <= '0;
        end else begin
            if (state == IDLE && enable) base <= selected ? BASE_SEL1 : BASE_SEL0;
            if (!enable || state == IDLE) count <= '0;
            else if (state == ACK_HI && !strobe_s) count <= count_inc;
            if (state == WAIT_REQ && enable && strobe_s) data_q <= in_data;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = enable ? WAIT_REQ : IDLE;
            WAIT_REQ: state_n = strobe_s ? WRITE : WAIT_REQ;
            WRITE:    state_n = ACK_HI;
            ACK_HI:   state_n = strobe_s ? ACK_HI : (count_inc == IMAGE_BYTES) ? DONE : WAIT_REQ;
            DONE:     state_n = DONE;
            default:  state_n = IDLE;
        endcase
        if (!enable) state_n = IDLE;
    end
    assign in_ack  = state == ACK_HI;
    assign wren    = state == WRITE && enable;
    assign busy    = state == WAIT_REQ || state == WRITE || state == ACK_HI;
    assign done    = state == DONE;
    assign address = (state == IDLE) ? '0 : base + count;
    assign wdata   = data_q;
endmodule

// File: tb/tb_input_gpio_loader.sv
// tb_input_gpio_loader: randomized host-handshake bench with a write scoreboard for input_gpio_loader.
module tb_input_gpio_loader;
    localparam logic [17:0] B0 = 18'h00000;
    localparam logic [17:0] B1 = 18'h1E846;
    localparam int          NB = 4;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, selected = 1'b0, in_strobe = 1'b0;
    logic [7:0]  in_data = 8'h00, wdata;
    logic [17:0] address;
    logic        in_ack, wren, busy, done;
    int          checks = 0, errors = 0;
    logic [25:0] wq[$];
    logic [17:0] exp_base, exp_count;
    input_gpio_loader #(.ADDR_W(18), .IMAGE_BYTES(18'd4), .BASE_SEL0(B0), .BASE_SEL1(B1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .selected(selected), .in_data(in_data),
        .in_strobe(in_strobe), .in_ack(in_ack), .address(address), .wdata(wdata),
        .wren(wren), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    // Writes are recorded just before the rising edge, where the memory would sample them.
    always @(negedge clk) begin
        #4;
        if (wren === 1'b1) wq.push_back({address, wdata});
    end
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic expect_write(input logic [17:0] a, input logic [7:0] d);
        logic [25:0] w;
        check("write_count", wq.size(), 1);
        if (wq.size() > 0) begin
            w = wq.pop_front();
            check("write_addr", w[25:8], a);
            check("write_data", w[7:0], d);
        end
        wq.delete();
    endtask
    task automatic send_byte(input logic [7:0] b, input int hold);
        in_data = b;
        in_strobe = 1'b1;
        for (int n = 0; n < 40 && !in_ack; n++) @(negedge clk);
        check("ack_rise", in_ack, 1);
        in_data = 8'($urandom);
        repeat (hold) @(negedge clk);
        in_strobe = 1'b0;
        for (int n = 0; n < 40 && in_ack; n++) @(negedge clk);
        check("ack_fall", in_ack, 0);
    endtask
    task automatic start(input logic sel);
        enable = 1'b1;
        selected = sel;
        exp_base = sel ? B1 : B0;
        exp_count = 0;
        repeat (2) @(negedge clk);
        selected = 1'($urandom);
    endtask
    task automatic stop();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_stop", {busy, done, in_ack, address}, 0);
    endtask
    task automatic model_byte(input int hold);
        logic [7:0] b;
        b = 8'($urandom);
        send_byte(b, hold);
        expect_write(exp_base + exp_count, b);
        exp_count++;
        check("busy_done", {busy, done}, (exp_count == NB) ? 2'b01 : 2'b10);
        if (exp_count != NB) check("addr_next", address, exp_base + exp_count);
    endtask
    initial begin
        logic [7:0] b;
        int         seen;
        repeat (3) @(negedge clk);
        check("reset_outputs", {in_ack, address, wdata, wren, busy, done}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_no_enable", {busy, done, address}, 0);
        // Single byte with edge-exact latency.
        start(1'b0);
        in_data = 8'hA5;
        in_strobe = 1'b1;
        @(negedge clk);
        check("e0_wren", wren, 0);
        @(negedge clk);
        check("e1_wren_ack", {wren, in_ack}, 0);
        @(negedge clk);
        check("e2_write", {wren, in_ack, address, wdata}, {1'b1, 1'b0, 18'h0, 8'hA5});
        @(negedge clk);
        check("e3_ack", {wren, in_ack}, 2'b01);
        in_strobe = 1'b0;
        @(negedge clk);
        check("f0_ack", in_ack, 1);
        @(negedge clk);
        check("f1_ack", in_ack, 1);
        @(negedge clk);
        check("f2_ack_addr", {in_ack, address}, {1'b0, 18'h1});
        expect_write(18'h0, 8'hA5);
        stop();
        // Full transfer into region 1 with fixed bytes, then an ignored fifth strobe.
        start(1'b1);
        for (int i = 1; i <= NB; i++) begin
            b = 8'(i * 8'h11);
            send_byte(b, 1);
            expect_write(B1 + 18'(i - 1), b);
        end
        check("full_done", {done, busy}, 2'b10);
        in_strobe = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (in_ack) seen++;
        end
        in_strobe = 1'b0;
        check("done_ignores_ack", seen, 0);
        check("done_ignores_wr", wq.size(), 0);
        stop();
        // Abort while in WRITE.
        start(1'b0);
        in_data = 8'($urandom);
        in_strobe = 1'b1;
        for (int n = 0; n < 10 && !wren; n++) @(negedge clk);
        check("abort_reach_write", wren, 1);
        enable = 1'b0;
        #1;
        check("abort_wren_comb", wren, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_ack) seen++;
        end
        check("abort_no_ack", seen, 0);
        check("abort_no_write", wq.size(), 0);
        in_strobe = 1'b0;
        repeat (3) @(negedge clk);
        start(1'b0);
        send_byte(8'h5A, 0);
        expect_write(B0, 8'h5A);
        exp_count = 1;
        // Long strobe with selected toggled mid-transfer.
        selected = ~selected;
        model_byte(50);
        stop();
        // Strobe already high before enable.
        b = 8'($urandom);
        in_data = b;
        in_strobe = 1'b1;
        repeat (5) @(negedge clk);
        selected = 1'($urandom);
        exp_base = selected ? B1 : B0;
        enable = 1'b1;
        @(negedge clk);
        check("pre_strobe_wait", {busy, wren}, 2'b10);
        @(negedge clk);
        check("pre_strobe_write", {wren, address, wdata}, {1'b1, exp_base, b});
        in_strobe = 1'b0;
        for (int n = 0; n < 40 && (in_ack || wren || !busy); n++) @(negedge clk);
        expect_write(exp_base, b);
        stop();
        // Randomized transfers with occasional aborts between bytes.
        for (int t = 0; t < 8; t++) begin
            start(1'($urandom));
            while (exp_count != NB) begin
                if (exp_count != 0 && $urandom_range(0, 5) == 0) begin
                    enable = 1'b0;
                    repeat (2) @(negedge clk);
                    check("rand_abort_idle", {busy, done}, 0);
                    start(1'($urandom));
                end
                model_byte($urandom_range(0, 4));
            end
            stop();
        end
        // Reset in the middle of a handshake.
        start(1'($urandom));
        b = 8'($urandom);
        in_data = b;
        in_strobe = 1'b1;
        for (int n = 0; n < 40 && !in_ack; n++) @(negedge clk);
        check("rst_reach_ack", in_ack, 1);
        expect_write(exp_base, b);
        #2 rst = 1'b1;
        #1 check("rst_async", {in_ack, address, wdata, wren, busy, done}, 0);
        in_strobe = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_idle", {busy, done, in_ack, address}, 0);
        check("rst_no_write", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
